// File: rtl/decoder_5to32_reg.sv
// Registered 5-to-32 one-hot decoder used as the register-file write select.
// The combinational decode is built from a 2-to-4 and a 3-to-8 predecode. A
// clocked, enable-gated copy of it is kept with a flag saying it was loaded.
module decoder_5to32_reg #(
   parameter int OUT_W = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic [4:0]       Adr,
   output logic [OUT_W-1:0] DegOut_c,
   output logic [OUT_W-1:0] DegOut,
   output logic             Valid
);

   // The output width is tied to the 5-bit address. Any other width cannot be a
   // one-hot decode of Adr, so elaboration stops.
   generate
      if (OUT_W != 32) begin : g_bad_width
         $error("decoder_5to32_reg: OUT_W must be 32");
      end
   endgenerate

   logic [3:0] pre_lo;
   logic [7:0] pre_hi;

   // Low predecode: one of four from Adr[1:0].
   always_comb begin
      pre_lo            = '0;
      pre_lo[Adr[1:0]]  = 1'b1;
   end

   // High predecode: one of eight from Adr[4:2].
   always_comb begin
      pre_hi            = '0;
      pre_hi[Adr[4:2]]  = 1'b1;
   end

   // Final AND plane. Bit i needs low group i%4 and high group i/4. Exactly one
   // pair is active, so the result is one-hot for every address.
   genvar i;
   generate
      for (i = 0; i < OUT_W; i++) begin : g_and
         assign DegOut_c[i] = pre_lo[i % 4] & pre_hi[i / 4];
      end
   endgenerate

   // Registered copy: reset clears it at once, En loads the decode, and it
   // holds otherwise. Valid marks that a load happened since the last reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         DegOut <= '0;
         Valid  <= 1'b0;
      end else if (En) begin
         DegOut <= DegOut_c;
         Valid  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_decoder_5to32_reg.sv
`timescale 1ns/1ps
// Randomised and directed checks of decoder_5to32_reg. The reference model
// treats the decode as a shift of 1 by the address and the register as a stored
// value that only changes on an enabled edge or on reset.
module tb_decoder_5to32_reg;

   logic        Clk;
   logic        Rst_n;
   logic        En;
   logic [4:0]  Adr;
   logic [31:0] DegOut_c;
   logic [31:0] DegOut;
   logic        Valid;

   int total = 0;
   int bad   = 0;

   // Reference state of the registered outputs.
   logic [31:0] mdl_q;
   logic        mdl_v;

   decoder_5to32_reg #(.OUT_W(32)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .En       (En),
      .Adr      (Adr),
      .DegOut_c (DegOut_c),
      .DegOut   (DegOut),
      .Valid    (Valid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [31:0] ref_dec(input logic [4:0] a);
      logic [31:0] one;
      one = 32'd1;
      return one << a;
   endfunction

   task automatic test_reset();
      Rst_n = 1'b0;
      En    = 1'b1;
      Adr   = 5'b10101;
      #1;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         total++;
         if (DegOut !== 32'h0) begin
            bad++;
            $display("FAIL reset_degout: got %h want %h", DegOut, 32'h0);
         end
         total++;
         if (Valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", Valid);
         end
         total++;
         if (DegOut_c !== 32'h0020_0000) begin
            bad++;
            $display("FAIL reset_degout_c: got %h want %h", DegOut_c, 32'h0020_0000);
         end
      end
   endtask

   task automatic test_comb_sweep();
      @(negedge Clk);
      Rst_n = 1'b1;
      En    = 1'b0;
      for (int a = 0; a < 32; a++) begin
         Adr = 5'(a);
         #0.002;
         total++;
         if (DegOut_c !== ref_dec(5'(a))) begin
            bad++;
            $display("FAIL comb_sweep adr=%0d: got %h want %h", a, DegOut_c, ref_dec(5'(a)));
         end
         total++;
         if ($countones(DegOut_c) != 1) begin
            bad++;
            $display("FAIL comb_popcount adr=%0d: got %0d want 1", a, $countones(DegOut_c));
         end
      end
      // Registered path must not have moved while En was low.
      total++;
      if (DegOut !== 32'h0 || Valid !== 1'b0) begin
         bad++;
         $display("FAIL comb_sweep_reg_idle: got %h/%b want 0/0", DegOut, Valid);
      end
   endtask

   task automatic test_reg_sweep();
      @(posedge Clk);
      #1;
      En  = 1'b1;
      Adr = 5'd0;
      for (int a = 0; a < 32; a++) begin
         Adr = 5'(a);
         @(posedge Clk);
         #1;
         total++;
         if (DegOut !== ref_dec(5'(a))) begin
            bad++;
            $display("FAIL reg_sweep adr=%0d: got %h want %h", a, DegOut, ref_dec(5'(a)));
         end
         total++;
         if (Valid !== 1'b1) begin
            bad++;
            $display("FAIL reg_sweep_valid adr=%0d: got %b want 1", a, Valid);
         end
      end
   endtask

   task automatic test_hold();
      Adr = 5'b00011;
      En  = 1'b1;
      @(posedge Clk);
      #1;
      En  = 1'b0;
      Adr = 5'b11110;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         total++;
         if (DegOut !== 32'h0000_0008) begin
            bad++;
            $display("FAIL hold_degout: got %h want %h", DegOut, 32'h0000_0008);
         end
         total++;
         if (DegOut_c !== 32'h4000_0000) begin
            bad++;
            $display("FAIL hold_degout_c: got %h want %h", DegOut_c, 32'h4000_0000);
         end
      end
   endtask

   task automatic test_async_reset();
      Adr = 5'd16;
      En  = 1'b1;
      @(posedge Clk);
      #1;
      En = 1'b0;
      total++;
      if (DegOut !== 32'h0001_0000) begin
         bad++;
         $display("FAIL async_preload: got %h want %h", DegOut, 32'h0001_0000);
      end
      #2;
      Rst_n = 1'b0;
      #1;
      total++;
      if (DegOut !== 32'h0 || Valid !== 1'b0) begin
         bad++;
         $display("FAIL async_clear: got %h/%b want 0/0", DegOut, Valid);
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      Adr   = 5'b00001;
      En    = 1'b1;
      @(posedge Clk);
      #1;
      total++;
      if (DegOut !== 32'h0000_0002 || Valid !== 1'b1) begin
         bad++;
         $display("FAIL async_reload: got %h/%b want %h/1", DegOut, Valid, 32'h0000_0002);
      end
   endtask

   task automatic test_random();
      // Bring the model in line with the DUT state left by the previous test.
      mdl_q = 32'h0000_0002;
      mdl_v = 1'b1;
      En    = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         @(posedge Clk);
         if (Rst_n && En) begin
            mdl_q = ref_dec(Adr);
            mdl_v = 1'b1;
         end
         #1;
         Adr   = 5'($urandom_range(0, 31));
         En    = 1'($urandom_range(0, 1));
         Rst_n = ($urandom_range(0, 31) != 0);
         if (!Rst_n) begin
            mdl_q = 32'h0;
            mdl_v = 1'b0;
         end
         @(negedge Clk);
         total++;
         if (DegOut !== mdl_q || Valid !== mdl_v) begin
            bad++;
            $display("FAIL random_reg cyc=%0d: got %h/%b want %h/%b", c, DegOut, Valid, mdl_q, mdl_v);
         end
         total++;
         if (DegOut_c !== ref_dec(Adr)) begin
            bad++;
            $display("FAIL random_comb cyc=%0d: got %h want %h", c, DegOut_c, ref_dec(Adr));
         end
         total++;
         if ($countones(DegOut) > 1) begin
            bad++;
            $display("FAIL random_onehot cyc=%0d: got %h want zero or one-hot", c, DegOut);
         end
      end
   endtask

   initial begin
      Rst_n = 1'b0;
      En    = 1'b0;
      Adr   = 5'd0;
      mdl_q = 32'h0;
      mdl_v = 1'b0;
      test_reset();
      test_comb_sweep();
      test_reg_sweep();
      test_hold();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder_5to32_reg.md
Name: decoder_5to32_reg

Overview:
- Registered 5-to-32 one-hot address decoder for the MIPS datapath. Its main use is register-file write-select: it turns a 5-bit register address into a 32-bit one-hot select vector.
- Provides a combinational decode and a clocked, enable-gated copy of the decode.
- The registered output is cleared by an asynchronous active-low reset.

Parameters:
- OUT_W, 32, output vector width; fixed at 2**5. Any other value is illegal; elaboration must error.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- En  input  1  load enable for registered output
- Adr  input  5  address to decode, unsigned 0..31
- DegOut_c  output  32  combinational decode of Adr
- DegOut  output  32  registered decode, one-hot or all-zero
- Valid  output  1  registered flag: DegOut holds a decoded value since last reset

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Combinational decode: DegOut_c[i] = 1 iff Adr == i, for i = 0..31. All other bits are 0.
- The decode is exactly one-hot for every Adr value, including 5'b00000 → bit 0 and 5'b11111 → bit 31.
- Decode structure: two-level predecode.
  - Adr[1:0] drives a 2-to-4 predecode.
  - Adr[4:2] drives a 3-to-8 predecode.
  - Output bit i = pre_lo[i%4] & pre_hi[i/4].
  - The result must be bit-identical to Adr == i.
- X handling: if Adr contains X or Z, DegOut_c may be X. No X-pessimism fix is required.
- Propagation: DegOut_c follows Adr with zero cycles latency and no clock dependence.
- Reset: Rst_n = 0 immediately, independent of Clk, forces:
  - DegOut = 32'h0000_0000
  - Valid = 0
- Reset is held for as long as Rst_n = 0. Deassertion is synchronized externally; the block needs no internal synchronizer.
- Registered path: on rising Clk with Rst_n = 1:
  - En = 1: DegOut <= DegOut_c, and Valid <= 1. Latency is 1 cycle from Adr/En sampled to DegOut.
  - En = 0: DegOut and Valid hold their previous values.
- Output invariant: DegOut is always either all-zero (after reset, before the first load) or exactly one-hot. Popcount must never be ≥ 2.
- Reset mid-operation: asserting Rst_n between edges clears DegOut asynchronously. The next enabled edge after deassertion reloads from the Adr value current at that edge.
- Simultaneous events: Rst_n low at a Clk edge with En = 1 means reset wins, and outputs stay 0.
- Adr changing while En = 0: DegOut_c tracks Adr; DegOut is unchanged.
- Back-to-back loads: consecutive enabled cycles update DegOut every cycle with no bubbles.

Test Plan:
- Reset: Rst_n = 0 with Adr = 5'b10101 and En = 1, then toggle Clk. DegOut = 32'h0 and Valid = 0 throughout, while DegOut_c = 32'h0020_0000.
- Exhaustive combinational sweep: Adr = 0..31 in order, 2 ps apart, Rst_n = 1 and En = 0. Check each point:
  - DegOut_c = 1 << Adr.
  - Popcount is 1.
  - Adr = 0 gives 32'h0000_0001; Adr = 31 gives 32'h8000_0000.
- Registered sweep: En = 1, Adr stepping 0..31 on each Clk edge. DegOut equals 1 << Adr sampled at that edge (1-cycle latency), and Valid = 1 after the first edge.
- Hold: load Adr = 5'b00011 (DegOut = 32'h0000_0008), set En = 0, change Adr to 5'b11110. DegOut stays 32'h0000_0008 while DegOut_c = 32'h4000_0000.
- Async reset mid-cycle: with DegOut = 32'h0001_0000, pulse Rst_n low between edges. DegOut = 0 and Valid = 0 immediately. Release, load Adr = 5'b00001 → DegOut = 32'h0000_0002.
- Invariant assertion: random Adr/En/Rst_n for 10k cycles. DegOut is 0 or one-hot at every cycle, and DegOut_c equals the reference 1 << Adr.
